// File: rtl/hazard_branch_ctrl.sv
// Hazard/redirect controller: producer history, forwarding selects, load-use stall,
// branch redirects with a multi-cycle flush and the EXEC sequencer. Optional: HAZ_PERF_CNT_EN.
module hazard_branch_ctrl #(
  parameter int RSIZE        = 4,
  parameter int FWD_DEPTH    = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int FSEL_W       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        opcode,
  input  logic [2:0]        cond,
  input  logic [2:0]        flag,
  input  logic [RSIZE-1:0]  addr_rd,
  input  logic [RSIZE-1:0]  addr_rs,
  input  logic [RSIZE-1:0]  addr_rt,
  output logic              stall,
  output logic              flush,
  output logic              pc_sel,
  output logic [1:0]        pc_src,
  output logic [FSEL_W-1:0] fwd_a,
  output logic [FSEL_W-1:0] fwd_b,
  output logic              exec_active,
  output logic              exec_illegal
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC_TGT, EXEC_RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic             hwen_q  [1:FWD_DEPTH];
  logic             hld_q   [1:FWD_DEPTH];
  logic [RSIZE-1:0] hdest_q [1:FWD_DEPTH];

  logic              tgt_mode, illegal_tgt, use_a, use_b, hit_a1, hit_b1;
  logic              stall_raw, flush_raw, eff, taken;
  logic              redir, act, ill, wr, wr_ld;
  logic [1:0]        src;
  logic [RSIZE-1:0]  b_addr, wr_dest;
  logic [FSEL_W-1:0] fa, fb;

  assign tgt_mode    = (state_q != IDLE);
  assign illegal_tgt = tgt_mode && (opcode[3:2] == 2'b11);
  assign use_a       = (opcode <= 4'd9);
  assign use_b       = !illegal_tgt &&
                       ((opcode <= 4'd3) || (opcode == 4'd9) || (opcode == 4'd14) || (opcode == 4'd15));
  assign b_addr      = (opcode <= 4'd3) ? addr_rt : addr_rd;

  // Older stages first so the youngest matching producer overrides.
  always_comb begin
    fa = '0;
    fb = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hwen_q[k] && hdest_q[k] == addr_rs && addr_rs != '0) fa = FSEL_W'(k);
      if (hwen_q[k] && hdest_q[k] == b_addr  && b_addr  != '0) fb = FSEL_W'(k);
    end
    hit_a1 = hwen_q[1] && hld_q[1] && hdest_q[1] == addr_rs && addr_rs != '0;
    hit_b1 = hwen_q[1] && hld_q[1] && hdest_q[1] == b_addr  && b_addr  != '0;
  end

  assign stall_raw = id_valid && ((use_a && hit_a1) || (use_b && hit_b1));
  assign flush_raw = (fcnt_q != 3'd0);
  assign eff       = id_valid && !flush_raw && !stall_raw;

  // flag = {N,V,Z}
  always_comb begin
    unique case (cond)
      3'd0: taken = flag[0];
      3'd1: taken = !flag[0];
      3'd2: taken = !flag[0] && !flag[2];
      3'd3: taken = flag[2];
      3'd4: taken = flag[0] || !flag[2];
      3'd5: taken = flag[0] || flag[2];
      3'd6: taken = flag[1];
      default: taken = 1'b1;
    endcase
  end

  always_comb begin
    redir   = 1'b0;
    src     = 2'd0;
    act     = 1'b0;
    ill     = 1'b0;
    state_d = state_q;
    if (!tgt_mode) begin
      if (eff) begin
        unique case (opcode)
          4'd12: begin redir = taken; src = taken ? 2'd1 : 2'd0; end
          4'd13: begin redir = 1'b1;  src = 2'd1; end
          4'd14: begin redir = 1'b1;  src = 2'd2; end
          4'd15: begin redir = 1'b1;  src = 2'd2; state_d = EXEC_TGT; end
          default: ;
        endcase
      end
    end else begin
      act = id_valid && !flush_raw;
      if (eff) begin
        redir   = 1'b1;
        src     = 2'd3;
        ill     = illegal_tgt;
        state_d = IDLE;
      end else if (act && stall_raw) begin
        state_d = EXEC_RUN;
      end
    end
  end

  assign wr      = eff && !illegal_tgt &&
                   ((opcode <= 4'd8) || (opcode == 4'd10) || (opcode == 4'd11) || (opcode == 4'd13));
  assign wr_dest = (opcode == 4'd13) ? {RSIZE{1'b1}} : addr_rd;
  assign wr_ld   = (opcode == 4'd8);
  assign fcnt_d  = redir ? 3'(FLUSH_CYCLES) : (flush_raw ? fcnt_q - 3'd1 : 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= 3'd0;
      for (int k = 1; k <= FWD_DEPTH; k++) hwen_q[k] <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      hwen_q[1] <= wr;
      for (int k = 2; k <= FWD_DEPTH; k++) hwen_q[k] <= hwen_q[k-1];
    end
  end

  // Destination/load tags are qualified by hwen_q, so they carry no reset.
  always_ff @(posedge clk) begin
    hdest_q[1] <= wr_dest;
    hld_q[1]   <= wr_ld;
    for (int k = 2; k <= FWD_DEPTH; k++) begin
      hdest_q[k] <= hdest_q[k-1];
      hld_q[k]   <= hld_q[k-1];
    end
  end

  assign stall        = rst_n && stall_raw;
  assign flush        = rst_n && flush_raw;
  assign pc_sel       = rst_n && redir;
  assign pc_src       = rst_n ? src : 2'd0;
  assign fwd_a        = (rst_n && id_valid && use_a) ? fa : '0;
  assign fwd_b        = (rst_n && id_valid && use_b) ? fb : '0;
  assign exec_active  = rst_n && act;
  assign exec_illegal = rst_n && ill;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_raw && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_raw && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
